// File: rtl/osd_cmd_arb.sv
// osd_cmd_arb: round-robin arbiter + word sequencer for the OSD host port.
// Ports: clk_sys/rst_n; per requester (a_*, b_*) req/cmd/len in, gnt and
//   data_rd pulses out, data in; io_osd/io_strobe/io_din port out; busy out.
module osd_cmd_arb #(
    parameter int STROBE_GAP = 2,
    parameter int LOW_GAP    = 4
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [7:0]  a_cmd,
    input  logic [8:0]  a_len,
    output logic        a_gnt,
    output logic        a_data_rd,
    input  logic [15:0] a_data,
    input  logic        b_req,
    input  logic [7:0]  b_cmd,
    input  logic [8:0]  b_len,
    output logic        b_gnt,
    output logic        b_data_rd,
    input  logic [15:0] b_data,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STRB,
        S_GAP,
        S_FETCH,
        S_LOAD,
        S_CLOSE
    } state_t;

    localparam logic [7:0] GAP_LD = 8'(STROBE_GAP);
    localparam logic [7:0] LOW_LD = 8'(LOW_GAP);

    state_t      r_state;
    logic        r_last;   // 1: B was served last
    logic        r_own;    // 1: B owns the current frame
    logic [8:0]  r_rem;
    logic [7:0]  r_cnt;

    logic        w_any;
    logic        w_pick_b;

    assign w_any    = a_req | b_req;
    // On a tie the requester that was not served last wins.
    assign w_pick_b = b_req & (~a_req | ~r_last);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_own     <= 1'b0;
            r_rem     <= '0;
            r_cnt     <= '0;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_data_rd <= 1'b0;
            b_data_rd <= 1'b0;
            io_osd    <= 1'b0;
            io_strobe <= 1'b0;
            io_din    <= '0;
            busy      <= 1'b0;
        end else begin
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_data_rd <= 1'b0;
            b_data_rd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_own   <= w_pick_b;
                        r_last  <= w_pick_b;
                        r_rem   <= w_pick_b ? b_len : a_len;
                        io_din  <= {8'h00, w_pick_b ? b_cmd : a_cmd};
                        a_gnt   <= ~w_pick_b;
                        b_gnt   <= w_pick_b;
                        io_osd  <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    io_strobe <= 1'b1;
                    r_state   <= S_STRB;
                end
                S_STRB: begin
                    io_strobe <= 1'b0;
                    r_cnt     <= GAP_LD;
                    r_state   <= S_GAP;
                end
                S_GAP: begin
                    if (r_cnt > 8'd1) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (r_rem != 9'd0) begin
                        // Pull pulse is visible during FETCH; the word
                        // is sampled on the edge that leaves FETCH.
                        a_data_rd <= ~r_own;
                        b_data_rd <= r_own;
                        r_rem     <= r_rem - 9'd1;
                        r_cnt     <= '0;
                        r_state   <= S_FETCH;
                    end else begin
                        io_osd  <= 1'b0;
                        io_din  <= '0;
                        r_cnt   <= LOW_LD;
                        r_state <= S_CLOSE;
                    end
                end
                S_FETCH: begin
                    io_din  <= r_own ? b_data : a_data;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    io_strobe <= 1'b1;
                    r_state   <= S_STRB;
                end
                S_CLOSE: begin
                    if (r_cnt > 8'd1) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_cmd_arb.sv
// tb_osd_cmd_arb: directed + randomized bench for osd_cmd_arb.
// Frame-level monitor feeds a transaction-level reference model.
module tb_osd_cmd_arb;

    localparam int G = 2;
    localparam int L = 4;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        a_req, b_req;
    logic [7:0]  a_cmd, b_cmd;
    logic [8:0]  a_len, b_len;
    logic        a_gnt, b_gnt;
    logic        a_data_rd, b_data_rd;
    logic [15:0] a_data, b_data;
    logic        io_osd, io_strobe, busy;
    logic [15:0] io_din;

    always #5 clk_sys = ~clk_sys;

    osd_cmd_arb #(.STROBE_GAP(G), .LOW_GAP(L)) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_cmd     (a_cmd),
        .a_len     (a_len),
        .a_gnt     (a_gnt),
        .a_data_rd (a_data_rd),
        .a_data    (a_data),
        .b_req     (b_req),
        .b_cmd     (b_cmd),
        .b_len     (b_len),
        .b_gnt     (b_gnt),
        .b_data_rd (b_data_rd),
        .b_data    (b_data),
        .io_osd    (io_osd),
        .io_strobe (io_strobe),
        .io_din    (io_din),
        .busy      (busy)
    );

    // Requesters: word list presented first-word-fall-through,
    // advancing after each pull pulse.
    logic [15:0] a_mem [512];
    logic [15:0] b_mem [512];
    logic [8:0]  a_ptr = '0;
    logic [8:0]  b_ptr = '0;
    assign a_data = a_mem[a_ptr];
    assign b_data = b_mem[b_ptr];

    always @(posedge clk_sys) begin
        if (a_gnt) a_ptr <= '0;
        else if (a_data_rd) a_ptr <= a_ptr + 9'd1;
        if (b_gnt) b_ptr <= '0;
        else if (b_data_rd) b_ptr <= b_ptr + 9'd1;
    end

    // Frame monitor
    int          proto_err = 0;
    int          done_cnt = 0;
    int          f_run = 0, f_len = 0, f_busy = 0, b_run = 0;
    int          low_run = 1000, min_low = 1000, strb_low = 0;
    int          f_ard = 0, f_brd = 0;
    bit          first_strb = 1'b1;
    bit          p_osd = 0, p_busy = 0, p_strb = 0, p_gnt = 0;
    bit          rd_d1 = 0, rd_d2 = 0;
    logic [15:0] p_din = '0;
    logic [15:0] f_strb [$];

    always @(negedge clk_sys) begin
        if (!rst_n) begin
            p_osd = 0; p_busy = 0; p_strb = 0; p_gnt = 0;
            rd_d1 = 0; rd_d2 = 0; p_din = '0;
            low_run = 1000; b_run = 0; f_run = 0;
        end else begin
            if (a_gnt && b_gnt) proto_err++;
            if ((a_gnt || b_gnt) && (p_busy || p_gnt)) proto_err++;
            if (io_osd && !p_osd) begin
                if (low_run < min_low) min_low = low_run;
                f_strb.delete();
                f_ard = 0; f_brd = 0; f_run = 0;
                first_strb = 1'b1; strb_low = 0;
            end
            if (io_osd) f_run++;
            if (!io_osd && p_osd) begin
                f_len = f_run; low_run = 0;
            end
            if (!io_osd) low_run++;
            if (busy) b_run = p_busy ? b_run + 1 : 1;
            if (!busy && p_busy) begin
                f_busy = b_run; done_cnt++;
            end
            if (io_strobe) begin
                f_strb.push_back(io_din);
                if (io_din !== p_din) proto_err++;
                if (p_strb) proto_err++;
                if (!first_strb && strb_low < G) proto_err++;
                if (first_strb == rd_d2) proto_err++;
                first_strb = 1'b0; strb_low = 0;
            end else begin
                strb_low++;
            end
            if (a_data_rd) f_ard++;
            if (b_data_rd) f_brd++;
            if (a_data_rd && b_data_rd) proto_err++;
            rd_d2 = rd_d1;
            rd_d1 = a_data_rd | b_data_rd;
            p_osd = io_osd; p_busy = busy;
            p_strb = io_strobe; p_din = io_din;
            p_gnt = a_gnt | b_gnt;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int m_last = 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: 0 = A, 1 = B.
    function automatic int pick(input bit ra, input bit rb);
        if (ra && rb) return (m_last == 1) ? 0 : 1;
        return ra ? 0 : 1;
    endfunction

    function automatic logic [31:0] outs();
        return 32'({a_gnt, b_gnt, a_data_rd, b_data_rd,
                    io_osd, io_strobe, busy, io_din});
    endfunction

    task automatic wait_gnt(input int own);
        int t = 0;
        #1;
        while (!(a_gnt || b_gnt) && t < 40) begin
            @(posedge clk_sys); #1; t++;
        end
        chk("gnt_seen", 32'(a_gnt | b_gnt), 32'd1);
        chk("gnt_owner", 32'({a_gnt, b_gnt}),
            (own == 0) ? 32'd2 : 32'd1);
    endtask

    task automatic check_frame(input int own, input logic [7:0] cmd,
                               input int len);
        int n0;
        int t;
        int bad;
        logic [15:0] ew;
        n0 = done_cnt;
        t = 0;
        while (done_cnt == n0 && t < len * (3 + G) + 60) begin
            @(posedge clk_sys); t++;
        end
        chk("frame_done", 32'(done_cnt != n0), 32'd1);
        chk("strb_count", 32'(f_strb.size()), 32'(len + 1));
        bad = 0;
        for (int i = 0; i <= len && i < f_strb.size(); i++) begin
            if (i == 0) ew = {8'h00, cmd};
            else ew = (own == 0) ? a_mem[i-1] : b_mem[i-1];
            if (f_strb[i] !== ew) bad++;
        end
        chk("strb_words", 32'(bad), 32'd0);
        chk("a_rd_pulses", 32'(f_ard), (own == 0) ? 32'(len) : 32'd0);
        chk("b_rd_pulses", 32'(f_brd), (own == 1) ? 32'(len) : 32'd0);
        chk("osd_high", 32'(f_len), 32'((2 + G) + len * (3 + G)));
        chk("busy_high", 32'(f_busy), 32'((2 + G) + len * (3 + G) + L));
    endtask

    task automatic rand_txn();
        bit ra, rb;
        int w, al, bl;
        ra = 1'($urandom);
        rb = 1'($urandom);
        if (!ra && !rb) ra = 1'b1;
        al = $urandom_range(0, 12);
        bl = $urandom_range(0, 12);
        a_cmd = 8'($urandom);
        b_cmd = 8'($urandom);
        a_len = 9'(al);
        b_len = 9'(bl);
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = 16'($urandom);
            b_mem[i] = 16'($urandom);
        end
        w = pick(ra, rb);
        a_req = ra;
        b_req = rb;
        wait_gnt(w);
        a_req = 1'b0;
        b_req = 1'b0;
        m_last = w;
        check_frame(w, (w == 1) ? b_cmd : a_cmd, (w == 1) ? bl : al);
    endtask

    initial begin
        int w;
        int t;
        logic [15:0] bdat [5];
        bdat[0] = 16'h0010; bdat[1] = 16'h0020; bdat[2] = 16'h0005;
        bdat[3] = 16'h0003; bdat[4] = 16'h0001;
        for (int i = 0; i < 512; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end
        rst_n = 1'b0;
        a_req = 0; b_req = 0;
        a_cmd = '0; b_cmd = '0; a_len = '0; b_len = '0;

        // Reset held: inputs toggling must not disturb outputs.
        for (int k = 0; k < 6; k++) begin
            a_req = 1'($urandom); b_req = 1'($urandom);
            a_cmd = 8'($urandom); b_cmd = 8'($urandom);
            a_len = 9'($urandom); b_len = 9'($urandom);
            @(negedge clk_sys);
            chk("rst_outputs", outs(), 32'd0);
        end
        a_req = 0; b_req = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat (2) @(negedge clk_sys);
            chk("idle_outputs", outs(), 32'd0);
        end

        // A, cmd 0x41, no data.
        a_cmd = 8'h41; a_len = 9'd0;
        a_req = 1'b1;
        w = pick(1, 0);
        wait_gnt(w);
        a_req = 1'b0;
        m_last = w;
        check_frame(w, 8'h41, 0);

        // B, cmd 0x45, five data words.
        b_cmd = 8'h45; b_len = 9'd5;
        for (int i = 0; i < 5; i++) b_mem[i] = bdat[i];
        b_req = 1'b1;
        w = pick(0, 1);
        wait_gnt(w);
        b_req = 1'b0;
        m_last = w;
        check_frame(w, 8'h45, 5);

        // Both held for three frames: re-arbitrated after each CLOSE.
        a_cmd = 8'h11; a_len = 9'd3;
        b_cmd = 8'h22; b_len = 9'd2;
        for (int i = 0; i < 4; i++) begin
            a_mem[i] = 16'($urandom);
            b_mem[i] = 16'($urandom);
        end
        a_req = 1'b1; b_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = pick(1, 1);
            wait_gnt(w);
            if (k == 2) begin
                a_req = 1'b0; b_req = 1'b0;
            end
            m_last = w;
            check_frame(w, (w == 1) ? 8'h22 : 8'h11, (w == 1) ? 2 : 3);
        end
        chk("min_osd_low", 32'(min_low), 32'(L + 1));

        // Long A frame with a counting data pattern.
        a_cmd = 8'h20; a_len = 9'd256;
        for (int i = 0; i < 256; i++) a_mem[i] = 16'(i);
        a_req = 1'b1;
        w = pick(1, 0);
        wait_gnt(w);
        a_req = 1'b0;
        m_last = w;
        check_frame(w, 8'h20, 256);

        for (int k = 0; k < 16; k++) rand_txn();

        // Async reset in the middle of a B frame.
        b_cmd = 8'h5A; b_len = 9'd6;
        for (int i = 0; i < 6; i++) b_mem[i] = 16'($urandom);
        b_req = 1'b1;
        wait_gnt(pick(0, 1));
        b_req = 1'b0;
        t = 0;
        while (f_brd < 3 && t < 100) begin
            @(negedge clk_sys); #2; t++;
        end
        chk("third_rd_seen", 32'(f_brd >= 3), 32'd1);
        chk("osd_before_rst", 32'(io_osd), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", outs(), 32'd0);
        repeat (3) @(negedge clk_sys);
        chk("rst_hold_outs", outs(), 32'd0);
        rst_n = 1'b1;
        m_last = 1;

        a_cmd = 8'h66; a_len = 9'd2;
        b_cmd = 8'h77; b_len = 9'd1;
        for (int i = 0; i < 2; i++) a_mem[i] = 16'($urandom);
        a_req = 1'b1; b_req = 1'b1;
        w = pick(1, 1);
        wait_gnt(w);
        a_req = 1'b0; b_req = 1'b0;
        m_last = w;
        check_frame(w, (w == 1) ? 8'h77 : 8'h66, (w == 1) ? 1 : 2);

        chk("protocol", 32'(proto_err), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
